// File: rtl/dm_pkg.sv
// Shared types and constants for the data-memory responder.
package dm_pkg;

  // Transaction phases: waiting for a request, counting latency, presenting the response.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dm_state_e;

  // Byte-enable patterns that can form a legal access.
  localparam logic [3:0] BE_W  = 4'b1111;
  localparam logic [3:0] BE_H0 = 4'b0011;
  localparam logic [3:0] BE_H1 = 4'b1100;
  localparam logic [3:0] BE_B0 = 4'b0001;
  localparam logic [3:0] BE_B1 = 4'b0010;
  localparam logic [3:0] BE_B2 = 4'b0100;
  localparam logic [3:0] BE_B3 = 4'b1000;

  // Width of the latency countdown; holds LATENCY values 0..15.
  localparam int LAT_W = 4;

endpackage

// File: rtl/dm_lane_check.sv
// Combinational legality check: the byte-enable / low-address pairing and the range check.
module dm_lane_check
  import dm_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic [31:0] addr,
  input  logic [3:0]  be,
  output logic        legal
);

  logic align_ok;
  logic in_range;

  // Only naturally aligned words, halfwords and bytes are accepted.
  always_comb begin
    align_ok = 1'b0;
    case (be)
      BE_W:    align_ok = (addr[1:0] == 2'b00);
      BE_H0:   align_ok = (addr[1:0] == 2'b00);
      BE_H1:   align_ok = (addr[1:0] == 2'b10);
      BE_B0:   align_ok = (addr[1:0] == 2'b00);
      BE_B1:   align_ok = (addr[1:0] == 2'b01);
      BE_B2:   align_ok = (addr[1:0] == 2'b10);
      BE_B3:   align_ok = (addr[1:0] == 2'b11);
      default: align_ok = 1'b0;
    endcase
  end

  // Any byte address beyond the memory capacity is rejected.
  assign in_range = ~(|addr[31:ADDR_W+2]);
  assign legal    = align_ok & in_range;

endmodule

// File: rtl/dm_responder.sv
// Variable-latency data-memory responder: one load/store at a time, commit on response entry.
module dm_responder
  import dm_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int              DEPTH    = 1 << ADDR_W;
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(LATENCY);
  localparam bit              LAT_ZERO = (LATENCY == 0);

  dm_state_e          state_reg;
  logic [LAT_W-1:0]   cnt_reg;
  logic               we_reg;
  logic [ADDR_W-1:0]  idx_reg;
  logic [3:0]         be_reg;
  logic [31:0]        wdata_reg;
  logic               legal_reg;

  logic               req_legal;
  logic               in_idle;
  logic               enter_resp;
  logic               acc_we;
  logic [ADDR_W-1:0]  acc_idx;
  logic [3:0]         acc_be;
  logic [31:0]        acc_wdata;
  logic               acc_legal;
  logic               commit_write;
  logic [31:0]        rd_word;

  dm_lane_check #(.ADDR_W(ADDR_W)) u_lane_check (
    .addr  (req_addr),
    .be    (req_be),
    .legal (req_legal)
  );

  // With zero latency the access commits on the accept edge itself, so the
  // commit path takes the live request in IDLE and the captured one otherwise.
  assign in_idle      = (state_reg == IDLE);
  assign enter_resp   = (in_idle && req_valid && LAT_ZERO) ||
                        (state_reg == WAIT && cnt_reg == LAT_W'(1));
  assign acc_we       = in_idle ? req_we                  : we_reg;
  assign acc_idx      = in_idle ? req_addr[ADDR_W+1:2]    : idx_reg;
  assign acc_be       = in_idle ? req_be                  : be_reg;
  assign acc_wdata    = in_idle ? req_wdata               : wdata_reg;
  assign acc_legal    = in_idle ? req_legal               : legal_reg;
  assign commit_write = enter_resp && acc_we && acc_legal;

  // One byte-wide array per lane so partial stores touch only their lanes.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem_lane [DEPTH];

    // Lane storage: cleared by reset, written only on a legal store's commit edge.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        mem_lane <= '{default: '0};
      end else if (commit_write && acc_be[gi]) begin
        mem_lane[acc_idx] <= acc_wdata[8*gi +: 8];
      end
    end

    assign rd_word[8*gi +: 8] = mem_lane[acc_idx];
  end

  // Transaction FSM with registered handshake and response outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      we_reg    <= 1'b0;
      idx_reg   <= '0;
      be_reg    <= '0;
      wdata_reg <= '0;
      legal_reg <= 1'b0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            we_reg    <= req_we;
            idx_reg   <= req_addr[ADDR_W+1:2];
            be_reg    <= req_be;
            wdata_reg <= req_wdata;
            legal_reg <= req_legal;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (LAT_ZERO) begin
              state_reg <= RESP;
            end else begin
              state_reg <= WAIT;
              cnt_reg   <= LAT_INIT;
            end
          end
        end
        WAIT: begin
          cnt_reg <= cnt_reg - LAT_W'(1);
          if (cnt_reg == LAT_W'(1)) begin
            state_reg <= RESP;
          end
        end
        RESP: begin
          state_reg <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase

      if (enter_resp) begin
        rsp_valid <= 1'b1;
        rsp_err   <= ~acc_legal;
        rsp_rdata <= (acc_legal && !acc_we) ? rd_word : 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
// Scoreboard bench: port 0 drives a LATENCY=2 instance, port 1 a LATENCY=0 instance.
module tb_dm_responder;

  localparam int ADDR_W = 12;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n     [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [31:0] req_addr  [2];
  logic [3:0]  req_be    [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];
  logic        busy      [2];

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  exp_t        sbq [2][$];
  logic [31:0] mdl [2][DEPTH];
  int          last_acc  [2];
  bit          last_hold [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(input int p);
    return (p == 0) ? 2 : 0;
  endfunction

  // Legal means: a 1/2/4-byte access, naturally aligned, whose enables cover exactly
  // the bytes starting at the address offset, and the address lies inside the memory.
  function automatic bit ref_legal(input logic [31:0] a, input logic [3:0] b);
    int n   = $countones(b);
    int off = int'(a[1:0]);
    if (a >= (32'd1 << (ADDR_W + 2))) return 1'b0;
    if (!(n == 1 || n == 2 || n == 4)) return 1'b0;
    if (off % n != 0) return 1'b0;
    return b == 4'(((1 << n) - 1) << off);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle_outputs(input int p, input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready[p]), 32'd1);
    chk({tag, "_busy"},      32'(busy[p]),      32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid[p]), 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata[p],      32'd0);
    chk({tag, "_rsp_err"},   32'(rsp_err[p]),   32'd0);
  endtask

  task automatic clear_model(input int p);
    for (int i = 0; i < DEPTH; i++) mdl[p][i] = 32'h0;
  endtask

  // Issue one request; 'hold' keeps req_valid high afterwards for back-to-back traffic,
  // 'expect_rsp'=0 is used when the transaction is going to be abandoned by reset.
  task automatic issue(input int p, input bit we, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] wd, input bit hold, input bit expect_rsp);
    int   n = 0;
    int   acc;
    bit   legal;
    exp_t e;
    @(negedge clk);
    req_valid[p] = 1'b1;
    req_we[p]    = we;
    req_addr[p]  = a;
    req_be[p]    = b;
    req_wdata[p] = wd;
    while (!req_ready[p] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: port %0d never ready", p);
    end
    acc = cyc + 1;
    if (last_hold[p]) chk("accept_gap", 32'(acc - last_acc[p]), 32'(lat_of(p) + 2));
    last_acc[p]  = acc;
    last_hold[p] = hold;
    if (expect_rsp) begin
      legal   = ref_legal(a, b);
      e.err   = ~legal;
      e.rdata = (legal && !we) ? mdl[p][a[ADDR_W+1:2]] : 32'h0;
      e.cyc   = acc + lat_of(p);
      if (legal && we)
        for (int i = 0; i < 4; i++)
          if (b[i]) mdl[p][a[ADDR_W+1:2]][8*i +: 8] = wd[8*i +: 8];
      sbq[p].push_back(e);
    end
    $display("port%0d %s addr=%h be=%b wdata=%h accept_cycle=%0d", p, we ? "ST" : "LD", a, b, wd, acc);
    @(posedge clk);
    #1;
    if (!hold) req_valid[p] = 1'b0;
  endtask

  task automatic drain(input int p);
    int n = 0;
    while (sbq[p].size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sbq[p].size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: port %0d has %0d pending", p, sbq[p].size());
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic random_ops(input int p, input int count);
    logic [3:0]  be_tab [7] = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8};
    logic [31:0] a;
    logic [3:0]  b;
    for (int k = 0; k < count; k++) begin
      a = {26'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 9) == 0) a = a | (32'd1 << $urandom_range(ADDR_W + 2, 31));
      b = ($urandom_range(0, 4) == 0) ? 4'($urandom) : be_tab[$urandom_range(0, 6)];
      issue(p, 1'($urandom), a, b, $urandom, 1'($urandom), 1'b1);
    end
    req_valid[p] = 1'b0;
    last_hold[p] = 1'b0;
    drain(p);
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    bit   after_rsp = 1'b0;
    exp_t e;

    dm_responder #(.ADDR_W(ADDR_W), .LATENCY(gi == 0 ? 2 : 0)) u_dut (
      .clk       (clk),
      .reset     (rst_n[gi]),
      .req_valid (req_valid[gi]),
      .req_ready (req_ready[gi]),
      .req_we    (req_we[gi]),
      .req_addr  (req_addr[gi]),
      .req_be    (req_be[gi]),
      .req_wdata (req_wdata[gi]),
      .rsp_valid (rsp_valid[gi]),
      .rsp_rdata (rsp_rdata[gi]),
      .rsp_err   (rsp_err[gi]),
      .busy      (busy[gi])
    );

    // Monitor: pops the scoreboard on every response and checks data, error and cycle.
    always @(negedge clk) begin
      if (!rst_n[gi]) begin
        after_rsp = 1'b0;
      end else begin
        if (after_rsp) begin
          chk("ready_after_rsp", 32'(req_ready[gi]), 32'd1);
          chk("busy_after_rsp",  32'(busy[gi]),      32'd0);
        end
        after_rsp = 1'b0;
        if (rsp_valid[gi]) begin
          if (sbq[gi].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: port %0d rdata=%h err=%b", gi, rsp_rdata[gi], rsp_err[gi]);
          end else begin
            e = sbq[gi].pop_front();
            chk("rsp_rdata", rsp_rdata[gi], e.rdata);
            chk("rsp_err",   32'(rsp_err[gi]), 32'(e.err));
            chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
            $display("port%0d RSP rdata=%h err=%b cycle=%0d", gi, rsp_rdata[gi], rsp_err[gi], cyc);
            after_rsp = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    for (int p = 0; p < 2; p++) begin
      rst_n[p] = 1'b0;
      req_valid[p] = 1'b0;
      req_we[p] = 1'b0;
      req_addr[p] = '0;
      req_be[p] = '0;
      req_wdata[p] = '0;
      last_acc[p] = 0;
      last_hold[p] = 1'b0;
      clear_model(p);
    end
    repeat (3) @(negedge clk);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    @(negedge clk);
    chk_idle_outputs(0, "reset0");
    chk_idle_outputs(1, "reset1");

    // Directed traffic on the LATENCY=2 instance.
    issue(0, 1'b1, 32'h10,   4'b1111, 32'hDEADBEEF, 1'b0, 1'b1);
    issue(0, 1'b0, 32'h10,   4'b1111, 32'h0,        1'b0, 1'b1);
    issue(0, 1'b1, 32'h11,   4'b0010, 32'h0000AB00, 1'b0, 1'b1);
    issue(0, 1'b0, 32'h10,   4'b1111, 32'h0,        1'b0, 1'b1);
    issue(0, 1'b0, 32'h12,   4'b1111, 32'h0,        1'b0, 1'b1);
    issue(0, 1'b1, 32'h13,   4'b0011, 32'hFFFFFFFF, 1'b0, 1'b1);
    issue(0, 1'b0, 32'h10,   4'b1111, 32'h0,        1'b0, 1'b1);
    issue(0, 1'b1, 32'h4000, 4'b1111, 32'h55AA55AA, 1'b0, 1'b1);
    issue(0, 1'b0, 32'h0,    4'b1111, 32'h0,        1'b0, 1'b1);
    drain(0);

    // Store abandoned by reset in the first WAIT cycle: no response, memory cleared.
    chk("busy_before_store", 32'(busy[0]), 32'd0);
    issue(0, 1'b1, 32'h20, 4'b1111, 32'h12345678, 1'b0, 1'b0);
    #1 rst_n[0] = 1'b0;
    #1 chk_idle_outputs(0, "mid_reset");
    clear_model(0);
    repeat (2) @(negedge clk);
    rst_n[0] = 1'b1;
    repeat (3) @(negedge clk);
    chk_idle_outputs(0, "after_reset");
    issue(0, 1'b0, 32'h20, 4'b1111, 32'h0, 1'b0, 1'b1);
    drain(0);

    random_ops(0, 40);

    // LATENCY=0 instance: back-to-back stores then three held loads.
    issue(1, 1'b1, 32'h8, 4'b1111, 32'hCAFEF00D, 1'b1, 1'b1);
    issue(1, 1'b1, 32'hC, 4'b0100, 32'h00770000, 1'b1, 1'b1);
    issue(1, 1'b0, 32'h8, 4'b1111, 32'h0,        1'b1, 1'b1);
    issue(1, 1'b0, 32'hC, 4'b1111, 32'h0,        1'b1, 1'b1);
    issue(1, 1'b0, 32'hE, 4'b1100, 32'h0,        1'b0, 1'b1);
    last_hold[1] = 1'b0;
    drain(1);

    random_ops(1, 40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_responder.md
# dm_responder

Variable-latency data-memory responder: the memory-side end of the CPU's load/store port. It accepts one load or store at a time over a valid/ready handshake, waits a programmable number of cycles, commits the access and returns a one-cycle response. The pipeline's MEM stage drives the request side and uses `busy` as a stall source. Lane extraction and sign extension stay in the CPU; this block returns whole aligned words.

## Interface
- `ADDR_W`, 12: word-address bits. Capacity is 2^ADDR_W words; the valid byte range is 0 .. 2^(ADDR_W+2)-1.
- `LATENCY`, 2: wait cycles between accept and response. Legal range is 0..15.

- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low: 0 resets the block immediately, independent of `clk`
- `req_valid`  in  1  request present
- `req_ready`  out  1  block can accept a request
- `req_we`  in  1  1 = store, 0 = load
- `req_addr`  in  32  byte address
- `req_be`  in  4  byte enables; bit i selects byte lane i, i.e. bits [8i+7:8i]
- `req_wdata`  in  32  store data, already lane-aligned
- `rsp_valid`  out  1  response strobe
- `rsp_rdata`  out  32  aligned word for loads; 0 for stores and errors
- `rsp_err`  out  1  request illegal; nothing was committed
- `busy`  out  1  a transaction is in flight

## Operation
- FSM states are IDLE, WAIT and RESP.
- IDLE
  - `req_ready`=1.
  - When `req_valid` is 1, the block captures we/addr/be/wdata and the legality result.
  - If LATENCY=0 it goes to RESP; otherwise it loads the counter with LATENCY and goes to WAIT.
- WAIT
  - The counter decrements every cycle.
  - On the cycle the counter equals 1, the next state is RESP.
- Entry edge into RESP
  - Legal store: write the enabled lanes only into `mem[addr[ADDR_W+1:2]]`.
  - Legal load: register the full word into `rsp_rdata`.
  - Illegal request or store: `rsp_rdata`=0.
  - `rsp_err` is registered at the same edge.
- RESP: `rsp_valid`=1 for exactly one cycle, then the next state is IDLE unconditionally.
- Legal `be`/`addr[1:0]` pairs:
  - 1111 / 00
  - 0011 / 00 and 1100 / 10
  - 0001 / 00, 0010 / 01, 0100 / 10, 1000 / 11
  - Every other pair is illegal, including `be`=0000.
- Out of range: any bit of `req_addr[31:ADDR_W+2]` set makes the request illegal.
- An illegal request walks the same state path and latency as a legal one, with `rsp_err`=1 and no memory write.
- `req_*` inputs are sampled only at the accept edge. While `req_ready`=0 they are ignored; the initiator holds them.
- `busy` = (state != IDLE).

## Timing
- Reset values:
  - state IDLE, counter 0
  - `req_ready`=1, `busy`=0
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0
  - every memory word cleared to 0
- Accept at edge T gives `rsp_valid` high in cycle T+LATENCY+1 and `req_ready` high again in cycle T+LATENCY+2.
- Maximum throughput is one request per LATENCY+2 cycles. With `req_valid` held high, accepts land exactly LATENCY+2 cycles apart.
- A store becomes visible to a load accepted in any later transaction; there is no same-transaction bypass.
- Reset asserted in WAIT or RESP abandons the transaction:
  - no write is committed, because commit happens only on the RESP entry edge;
  - no response is issued;
  - after release the block is in IDLE with `req_ready`=1.
- All outputs are registered or decoded from registered state. There is no combinational path from `req_*` to any output.

## Structure
- Package `dm_pkg` holds:
  - the state enum (IDLE/WAIT/RESP)
  - the legal byte-enable constants BE_W=1111, BE_H0=0011, BE_H1=1100, BE_B0..BE_B3
  - `LAT_W`=4 for the counter width
- Sub-module `dm_lane_check` is purely combinational.
  - Inputs: `addr`, `be`.
  - Output: `legal`, covering both the alignment pairs and the range check.

## Test plan
1. Defaults (ADDR_W=12, LATENCY=2).
   - After reset, store 0xDEADBEEF to 0x10 with be 1111 and accept at edge 0 -> `rsp_valid`=1 in cycle 3, `rsp_err`=0, `rsp_rdata`=0, `req_ready`=1 in cycle 4.
   - Then load 0x10 -> `rsp_rdata`=0xDEADBEEF.
2. Store 0x0000AB00 to 0x11 with be 0010, then load 0x10 -> `rsp_rdata`=0xDEADABEF.
3. Load 0x12 with be 1111, then store to 0x13 with be 0011 -> both return `rsp_err`=1 with `rsp_rdata`=0 at LATENCY+1 after accept; a subsequent load of 0x10 is unchanged.
4. Store to 0x4000 (out of range) -> `rsp_err`=1, and a load of 0x0 still returns 0.
5. Store 0x12345678 to 0x20, then drive `reset` low in cycle 1 of WAIT -> no `rsp_valid`, outputs at reset values.
   - After release, a load of 0x20 returns 0 and `busy` is 0 before the new accept.
6. LATENCY=0 with `req_valid` held high over three loads -> accepts at edges 0, 2, 4 and `rsp_valid` in cycles 1, 3, 5.
